// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI transfer queue.
package spi_pkg;

  localparam int unsigned DataWidth = 16;

  // Transfer sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitDone,
    StCapture
  } state_e;

  // Occupancy counters need one extra bit to represent "full".
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_xfer_queue_if.sv
// Host stream and SPI-master control signals of the transfer queue.
interface spi_xfer_queue_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth
) ();

  // Host TX stream
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  // Host RX stream
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  // SPI master control
  logic                  spi_start_tx;
  logic [DATA_WIDTH-1:0] spi_tx_data;
  logic                  spi_busy;
  logic                  spi_done;
  logic [DATA_WIDTH-1:0] spi_rx_data;

  // Queue side
  modport slave (
    input  s_valid, s_data, m_ready, spi_busy, spi_done, spi_rx_data,
    output s_ready, m_valid, m_data, spi_start_tx, spi_tx_data
  );

  // Host / SPI-master side
  modport master (
    output s_valid, s_data, m_ready, spi_busy, spi_done, spi_rx_data,
    input  s_ready, m_valid, m_data, spi_start_tx, spi_tx_data
  );

endinterface

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with exact occupancy count.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = DataWidth,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CntW = cnt_width(DEPTH),
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // Head is forced to zero when empty so the output never shows stale data.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and count next-state; pointers wrap naturally at power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_en_i) rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({wr_en_i, rd_en_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  wr_on_full_a:  assert property (@(posedge clk) disable iff (!rst_n) !(wr_en_i && full_o));
  rd_on_empty_a: assert property (@(posedge clk) disable iff (!rst_n) !(rd_en_i && empty_o));

endmodule

// File: rtl/spi_xfer_queue.sv
// Queues host words into SPI transfers and collects the received words,
// with a watchdog that abandons transfers whose completion never arrives.
module spi_xfer_queue
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DataWidth,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned CntW = cnt_width(FIFO_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_xfer_queue_if.slave bus,
  output logic [CntW-1:0] tx_count,
  output logic [CntW-1:0] rx_count,
  output logic            timeout_err,
  output logic            idle
);

  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic                  tx_full, tx_empty, tx_wr, tx_rd;
  logic [DATA_WIDTH-1:0] tx_head;
  logic                  rx_full, rx_empty, rx_wr, rx_rd;
  logic [DATA_WIDTH-1:0] rx_head;

  state_e                state_q, state_d;
  logic [WdW-1:0]        wd_q, wd_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0] rx_word_q, rx_word_d;
  logic                  start_q, start_d;
  logic                  err_q, err_d;

  // s_ready comes from registered full only, so a full FIFO never takes a push.
  assign tx_wr       = bus.s_valid && !tx_full;
  assign rx_rd       = !rx_empty && bus.m_ready;
  assign bus.s_ready = !tx_full;
  assign bus.m_valid = !rx_empty;
  assign bus.m_data  = rx_head;

  spi_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (tx_wr),
    .wr_data_i (bus.s_data),
    .rd_en_i   (tx_rd),
    .rd_data_o (tx_head),
    .full_o    (tx_full),
    .empty_o   (tx_empty),
    .count_o   (tx_count)
  );

  spi_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (rx_wr),
    .wr_data_i (rx_word_q),
    .rd_en_i   (rx_rd),
    .rd_data_o (rx_head),
    .full_o    (rx_full),
    .empty_o   (rx_empty),
    .count_o   (rx_count)
  );

  // Sequencer next-state: launch, wait for done or watchdog, then capture.
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    tx_data_d = tx_data_q;
    rx_word_d = rx_word_q;
    start_d   = 1'b0;
    err_d     = err_q;
    tx_rd     = 1'b0;
    rx_wr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // RX space is reserved up front so a completed word always has a slot.
        if (!tx_empty && !rx_full && !bus.spi_busy) state_d = StLaunch;
      end
      StLaunch: begin
        // Start is registered alongside the data so both reach the master together.
        tx_rd     = 1'b1;
        tx_data_d = tx_head;
        start_d   = 1'b1;
        wd_d      = '0;
        state_d   = StWaitDone;
      end
      StWaitDone: begin
        if (bus.spi_done) begin
          rx_word_d = bus.spi_rx_data;
          state_d   = StCapture;
        end else if (wd_q == WdLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StCapture: begin
        rx_wr   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer, watchdog and SPI-side output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wd_q      <= '0;
      tx_data_q <= '0;
      rx_word_q <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      tx_data_q <= tx_data_d;
      rx_word_q <= rx_word_d;
      start_q   <= start_d;
      err_q     <= err_d;
    end
  end

  assign bus.spi_start_tx = start_q;
  assign bus.spi_tx_data  = tx_data_q;
  assign timeout_err      = err_q;
  assign idle             = (state_q == StIdle) && tx_empty;

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Directed bench for spi_xfer_queue: table-driven push vectors plus
// hand-written sequences against a loopback SPI master model.
module tb_spi_xfer_queue;
  import spi_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_xfer_queue_if #(.DATA_WIDTH(DW)) ifc ();
  spi_xfer_queue_if #(.DATA_WIDTH(DW)) ifc2 ();

  logic [CW-1:0] tx_count, rx_count, tx_count2, rx_count2;
  logic          timeout_err, idle, timeout_err2, idle2;

  spi_xfer_queue #(
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (16),
    .TIMEOUT_CYCLES (4096)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (ifc),
    .tx_count    (tx_count),
    .rx_count    (rx_count),
    .timeout_err (timeout_err),
    .idle        (idle)
  );

  // Second instance with a short watchdog and an SPI master that never finishes.
  spi_xfer_queue #(
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (16),
    .TIMEOUT_CYCLES (16)
  ) u_dut_to (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (ifc2),
    .tx_count    (tx_count2),
    .rx_count    (rx_count2),
    .timeout_err (timeout_err2),
    .idle        (idle2)
  );

  assign ifc2.spi_busy    = 1'b0;
  assign ifc2.spi_done    = 1'b0;
  assign ifc2.spi_rx_data = '0;

  // Loopback SPI master model: done arrives done_delay cycles after start.
  int          done_delay;
  logic        busy_force, spur_done;
  logic        mdl_act, mdl_busy, mdl_done;
  logic [DW-1:0] mdl_sh, mdl_rx;
  int          mdl_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_act <= 1'b0; mdl_busy <= 1'b0; mdl_done <= 1'b0;
      mdl_cnt <= 0; mdl_sh <= '0; mdl_rx <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (ifc.spi_start_tx) begin
        mdl_act <= 1'b1; mdl_busy <= 1'b1; mdl_sh <= ifc.spi_tx_data; mdl_cnt <= 1;
      end else if (mdl_act) begin
        if (mdl_cnt >= done_delay - 1) begin
          mdl_done <= 1'b1; mdl_rx <= mdl_sh; mdl_act <= 1'b0; mdl_busy <= 1'b0;
        end else begin
          mdl_cnt <= mdl_cnt + 1;
        end
      end
    end
  end

  assign ifc.spi_busy    = mdl_busy | busy_force;
  assign ifc.spi_done    = mdl_done | spur_done;
  assign ifc.spi_rx_data = mdl_rx;

  int n_starts = 0;
  always @(posedge clk) if (ifc.spi_start_tx) n_starts <= n_starts + 1;

  int n_checks = 0;
  int n_err = 0;
  int stalls = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    int            exp_tx;
    logic          exp_ready;
    logic          exp_idle;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_ready"}, 32'(ifc.s_ready), 1);
    chk({tag, "_m_valid"}, 32'(ifc.m_valid), 0);
    chk({tag, "_m_data"}, 32'(ifc.m_data), 0);
    chk({tag, "_start"}, 32'(ifc.spi_start_tx), 0);
    chk({tag, "_tx_data"}, 32'(ifc.spi_tx_data), 0);
    chk({tag, "_tx_count"}, 32'(tx_count), 0);
    chk({tag, "_rx_count"}, 32'(rx_count), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    chk({tag, "_idle"}, 32'(idle), 1);
  endtask

  // Offer one word until accepted; a refused cycle must mean a full TX FIFO.
  task automatic push(input logic [DW-1:0] d);
    int   g;
    logic acc;
    ifc.s_valid = 1'b1;
    ifc.s_data  = d;
    acc = 1'b0;
    g = 0;
    while (!acc && g < 500) begin
      acc = ifc.s_ready;
      if (!acc) begin
        stalls++;
        chk("full_when_not_ready", 32'(tx_count), 16);
      end
      tick();
      g++;
    end
    ifc.s_valid = 1'b0;
    if (acc) exp_q.push_back(d);
    else chk("push_accepted", 0, 1);
  endtask

  // Pop every expected word, comparing order and value.
  task automatic drain();
    int g;
    g = 0;
    ifc.m_ready = 1'b1;
    while (exp_q.size() > 0 && g < 3000) begin
      if (ifc.m_valid) chk("drain_data", 32'(ifc.m_data), 32'(exp_q.pop_front()));
      tick();
      g++;
    end
    ifc.m_ready = 1'b0;
    chk("drain_all_received", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, g;
    ifc.s_valid = 1'b0; ifc.s_data = '0; ifc.m_ready = 1'b0;
    ifc2.s_valid = 1'b0; ifc2.s_data = '0; ifc2.m_ready = 1'b0;
    busy_force = 1'b0; spur_done = 1'b0; done_delay = 40;

    vecs[0] = '{1'b0, 16'h0000, 0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 16'h0001, 1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 16'h0002, 2, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 16'hdead, 2, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16'h0003, 3, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 16'h0004, 4, 1'b1, 1'b0};

    // Reset values
    repeat (3) tick();
    chk_reset("rst");
    rst_n = 1'b1;
    tick();

    // Single word through loopback, done 40 cycles after start
    base = n_starts;
    ifc.s_valid = 1'b1; ifc.s_data = 16'hA5A5;
    tick();
    ifc.s_valid = 1'b0;
    chk("a_tx_count_after_push", 32'(tx_count), 1);
    chk("a_start_at_1", 32'(ifc.spi_start_tx), 0);
    tick();
    chk("a_start_at_1b", 32'(ifc.spi_start_tx), 0);
    tick();
    chk("a_start_at_2", 32'(ifc.spi_start_tx), 1);
    chk("a_tx_data", 32'(ifc.spi_tx_data), 32'hA5A5);
    g = 0;
    while (!ifc.spi_done && g < 200) begin tick(); g++; end
    chk("a_done_latency", g, 40);
    tick();
    chk("a_m_valid_done+1", 32'(ifc.m_valid), 0);
    tick();
    chk("a_m_valid_done+2", 32'(ifc.m_valid), 1);
    chk("a_m_data", 32'(ifc.m_data), 32'hA5A5);
    chk("a_tx_data_held", 32'(ifc.spi_tx_data), 32'hA5A5);
    chk("a_timeout_err", 32'(timeout_err), 0);
    chk("a_one_start", n_starts - base, 1);
    ifc.m_ready = 1'b1;
    tick();
    ifc.m_ready = 1'b0;
    chk("a_rx_empty_after_pop", 32'(rx_count), 0);

    // Table-driven pushes with launches blocked by busy
    busy_force = 1'b1;
    tick();
    foreach (vecs[i]) begin
      ifc.s_valid = vecs[i].valid;
      ifc.s_data  = vecs[i].data;
      tick();
      if (vecs[i].valid) exp_q.push_back(vecs[i].data);
      chk($sformatf("vec%0d_tx_count", i), 32'(tx_count), 32'(vecs[i].exp_tx));
      chk($sformatf("vec%0d_s_ready", i), 32'(ifc.s_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_idle", i), 32'(idle), 32'(vecs[i].exp_idle));
    end
    ifc.s_valid = 1'b0;

    // Fill to 16 words; s_ready must drop exactly at full
    for (int i = 5; i <= 16; i++) begin
      ifc.s_valid = 1'b1;
      ifc.s_data  = 16'(16'h0100 + i);
      tick();
      exp_q.push_back(16'(16'h0100 + i));
      if (i == 15) chk("fill_ready_at_15", 32'(ifc.s_ready), 1);
    end
    ifc.s_data = 16'hBAD0;
    tick();
    ifc.s_valid = 1'b0;
    chk("fill_tx_count_16", 32'(tx_count), 16);
    chk("fill_s_ready_low", 32'(ifc.s_ready), 0);

    // 16 transfers fill RX with m_ready low; 17th must wait for a pop
    base = n_starts;
    done_delay = 5;
    busy_force = 1'b0;
    g = 0;
    while (rx_count != 16 && g < 400) begin tick(); g++; end
    chk("full_rx_count", 32'(rx_count), 16);
    chk("full_tx_count", 32'(tx_count), 0);
    chk("full_starts", n_starts - base, 16);
    push(16'h0117);
    repeat (20) tick();
    chk("no_17th_launch", n_starts - base, 16);
    chk("17th_queued", 32'(tx_count), 1);
    chk("head_word", 32'(ifc.m_data), 32'(exp_q[0]));
    void'(exp_q.pop_front());
    ifc.m_ready = 1'b1;
    tick();
    ifc.m_ready = 1'b0;
    g = 0;
    while (!ifc.spi_start_tx && g < 10) begin tick(); g++; end
    chk("17th_launch_after_pop", 32'(ifc.spi_start_tx), 1);
    chk("17th_tx_data", 32'(ifc.spi_tx_data), 32'h0117);
    drain();

    // Burst of 20 with concurrent draining
    base = n_starts;
    stalls = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) push(16'(16'h2000 + i));
      end
      begin
        int got, gg;
        got = 0;
        gg = 0;
        ifc.m_ready = 1'b1;
        while (got < 20 && gg < 3000) begin
          if (ifc.m_valid) begin
            chk("burst_data", 32'(ifc.m_data), 32'(exp_q.pop_front()));
            got++;
          end
          tick();
          gg++;
        end
        ifc.m_ready = 1'b0;
        chk("burst_count", got, 20);
      end
    join
    chk("burst_s_ready_dropped", 32'(stalls > 0), 1);
    chk("burst_starts", n_starts - base, 20);
    chk("burst_no_leftover", exp_q.size(), 0);
    chk("burst_timeout_err", 32'(timeout_err), 0);

    // Spurious done in IDLE, then launch held off by busy
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    repeat (3) tick();
    chk("spur_rx_count", 32'(rx_count), 0);
    chk("spur_m_valid", 32'(ifc.m_valid), 0);
    chk("spur_idle", 32'(idle), 1);
    busy_force = 1'b1;
    base = n_starts;
    push(16'h3C3C);
    repeat (10) tick();
    chk("busy_no_launch", n_starts - base, 0);
    chk("busy_tx_count", 32'(tx_count), 1);
    busy_force = 1'b0;
    tick();
    chk("busy_release_start_1", 32'(ifc.spi_start_tx), 0);
    tick();
    chk("busy_release_start_2", 32'(ifc.spi_start_tx), 1);
    chk("busy_release_data", 32'(ifc.spi_tx_data), 32'h3C3C);
    drain();

    // Reset during WAIT_DONE with words queued
    done_delay = 40;
    push(16'h4001);
    push(16'h4002);
    push(16'h4003);
    repeat (5) tick();
    chk("mid_tx_count", 32'(tx_count), 2);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    base = n_starts;
    repeat (20) tick();
    chk("post_rst_no_start", n_starts - base, 0);
    chk("post_rst_idle", 32'(idle), 1);
    push(16'h4444);
    tick();
    tick();
    chk("post_rst_launch", 32'(ifc.spi_start_tx), 1);
    chk("post_rst_data", 32'(ifc.spi_tx_data), 32'h4444);
    drain();

    // Watchdog abort on the short-timeout instance
    ifc2.s_valid = 1'b1; ifc2.s_data = 16'h1111;
    tick();
    ifc2.s_data = 16'h2222;
    tick();
    ifc2.s_valid = 1'b0;
    tick();
    chk("to_start", 32'(ifc2.spi_start_tx), 1);
    chk("to_tx_data", 32'(ifc2.spi_tx_data), 32'h1111);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) chk("to_err_at_15", 32'(timeout_err2), 0);
      if (k == 16) chk("to_err_at_16", 32'(timeout_err2), 1);
    end
    tick();
    chk("to_next_start_17", 32'(ifc2.spi_start_tx), 0);
    tick();
    chk("to_next_start_18", 32'(ifc2.spi_start_tx), 1);
    chk("to_next_data", 32'(ifc2.spi_tx_data), 32'h2222);
    chk("to_no_rx_word", 32'(rx_count2), 0);
    repeat (20) tick();
    chk("to_err_sticky", 32'(timeout_err2), 1);
    chk("to_idle_after", 32'(idle2), 1);
    chk("to_m_valid", 32'(ifc2.m_valid), 0);
    chk("main_no_timeout", 32'(timeout_err), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
